// File: rtl/led_display_pkg.sv
// Shared types and constants for the LED display arbiter slice.
package led_display_pkg;
  localparam int VALUE_W  = 16;
  localparam int NIBBLE_W = 4;
  localparam int CLK_HZ   = 12_000_000;

  typedef logic [VALUE_W-1:0] disp_value_t;
  typedef enum logic {IDLE, SHOW} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req after 'last', wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);
  localparam int IW = $clog2(N);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    if (en) begin
      // k == N revisits 'last' itself, so a sole requester can win again
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last) + k) % N;
        if (!any_grant && req[idx]) begin
          any_grant      = 1'b1;
          grant[idx]     = 1'b1;
          grant_idx      = IW'(idx);
        end
      end
    end
  end
endmodule

// File: rtl/led_display_arbiter.sv
// Time-shares the 16-bit LED display among requesters, holding each accepted value HOLD_CYCLES.
module led_display_arbiter
  import led_display_pkg::*;
#(
  parameter int                 NUM_REQ     = 4,
  parameter int                 HOLD_CYCLES = 4 * CLK_HZ,
  parameter logic [VALUE_W-1:0] IDLE_VALUE  = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*VALUE_W-1:0]   req_value,
  output logic [NUM_REQ-1:0]           req_ready,
  output disp_value_t                  disp_value,
  output logic                         disp_active,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);
  localparam int            IW       = $clog2(NUM_REQ);
  localparam int            CW       = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  arb_state_e    state_q, state_d;
  disp_value_t   disp_q, disp_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic               accept;
  logic [NUM_REQ-1:0] sel_grant;
  logic [IW-1:0]      sel_idx;
  logic               sel_any;
  disp_value_t        sel_value;

  // A new value may only be taken while idle or on the final cycle of a hold
  assign accept    = (state_q == IDLE) || (cnt_q == CNT_LAST);
  assign sel_value = req_value[int'(sel_idx)*VALUE_W +: VALUE_W];

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .en        (accept && rst_n),
    .grant     (sel_grant),
    .grant_idx (sel_idx),
    .any_grant (sel_any)
  );

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == SHOW) cnt_d = cnt_q + CW'(1);
    if (accept) begin
      if (sel_any) begin
        state_d = SHOW;
        disp_d  = sel_value;
        gid_d   = sel_idx;
        last_d  = sel_idx;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        disp_d  = IDLE_VALUE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      disp_q  <= IDLE_VALUE;
      gid_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready   = sel_grant;
  assign disp_value  = disp_q;
  assign disp_active = (state_q == SHOW);
  assign grant_id    = gid_q;
endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed bench for led_display_arbiter with NUM_REQ=4, HOLD_CYCLES=8.
module tb_led_display_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_value;
  logic [3:0]  req_ready;
  logic [15:0] disp_value;
  logic        disp_active;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  led_display_arbiter #(
    .NUM_REQ(4), .HOLD_CYCLES(8), .IDLE_VALUE(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .disp_value(disp_value), .disp_active(disp_active),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  logic [15:0] vals [4];

  initial begin
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    rst_n = 1'b0; req_valid = '0; req_value = '0;

    // 1: reset state and 20 idle cycles
    cyc(); cyc(); #1;
    chk("rst_disp", 32'(disp_value), 32'h0);
    chk("rst_active", 32'(disp_active), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk("idle_disp", 32'(disp_value), 32'h0);
      chk("idle_active", 32'(disp_active), 32'h0);
      chk("idle_ready", 32'(req_ready), 32'h0);
    end

    // 2: single request from requester 1
    cyc();
    req_valid = 4'b0010; req_value[31:16] = 16'hC931; #1;
    chk("s2_ready", 32'(req_ready), 32'b0010);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) req_valid = '0;
      #1;
      chk("s2_disp", 32'(disp_value), 32'hC931);
      chk("s2_active", 32'(disp_active), 32'h1);
      chk("s2_gid", 32'(grant_id), 32'h1);
      chk("s2_ready_hold", 32'(req_ready), 32'h0);
    end
    cyc(); #1;
    chk("s2_end_disp", 32'(disp_value), 32'h0);
    chk("s2_end_active", 32'(disp_active), 32'h0);
    chk("s2_end_gid", 32'(grant_id), 32'h1);

    // 3: all four requesters, granted 0..3 back-to-back
    do_reset();
    cyc();
    req_valid = 4'b1111;
    for (int g = 0; g < 4; g++) req_value[16*g +: 16] = vals[g];
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("s3_ready", 32'(req_ready), 32'(1 << g));
      for (int i = 0; i < 8; i++) begin
        cyc();
        if (i == 0) req_valid[g] = 1'b0;
        #1;
        chk("s3_disp", 32'(disp_value), 32'(vals[g]));
        chk("s3_active", 32'(disp_active), 32'h1);
        chk("s3_gid", 32'(grant_id), 32'(g));
        if (i < 7) chk("s3_ready_hold", 32'(req_ready), 32'h0);
      end
    end
    chk("s3_last_ready", 32'(req_ready), 32'h0);
    cyc(); #1;
    chk("s3_end_disp", 32'(disp_value), 32'h0);
    chk("s3_end_active", 32'(disp_active), 32'h0);

    // 4: fairness, req0 continuous, req2 joins at hold cycle 3
    do_reset();
    cyc();
    req_valid = 4'b0001; req_value[15:0] = 16'hA0A0; #1;
    chk("s4_acc0", 32'(req_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 3) begin req_valid[2] = 1'b1; req_value[47:32] = 16'hB2B2; end
      #1;
      chk("s4_disp0", 32'(disp_value), 32'hA0A0);
      chk("s4_gid0", 32'(grant_id), 32'h0);
      chk("s4_ready0", 32'(req_ready), (i < 7) ? 32'h0 : 32'b0100);
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) req_valid[2] = 1'b0;
      #1;
      chk("s4_disp2", 32'(disp_value), 32'hB2B2);
      chk("s4_gid2", 32'(grant_id), 32'h2);
      chk("s4_ready2", 32'(req_ready), (i < 7) ? 32'h0 : 32'b0001);
    end

    // 5: req3 raises then withdraws during req0's hold
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) req_valid[0] = 1'b0;
      if (i == 2) begin req_valid[3] = 1'b1; req_value[63:48] = 16'hD3D3; end
      if (i == 5) req_valid[3] = 1'b0;
      #1;
      chk("s5_disp", 32'(disp_value), 32'hA0A0);
      chk("s5_gid", 32'(grant_id), 32'h0);
      chk("s5_ready", 32'(req_ready), 32'h0);
    end
    cyc(); #1;
    chk("s5_end_disp", 32'(disp_value), 32'h0);
    chk("s5_end_active", 32'(disp_active), 32'h0);
    chk("s5_end_ready", 32'(req_ready), 32'h0);

    // 6: reset during a hold, then requester 0 wins first
    cyc();
    req_valid = 4'b0010; req_value[31:16] = 16'h6161; #1;
    chk("s6_acc", 32'(req_ready), 32'b0010);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) req_valid = '0;
      if (i == 4) begin
        rst_n = 1'b0;
        req_valid = 4'b1111;
        for (int g = 0; g < 4; g++) req_value[16*g +: 16] = vals[g];
      end
      #1;
      chk("s6_disp", 32'(disp_value), 32'h6161);
      if (i == 4) chk("s6_rst_ready", 32'(req_ready), 32'h0);
    end
    cyc(); #1;
    chk("s6_rst_disp", 32'(disp_value), 32'h0);
    chk("s6_rst_active", 32'(disp_active), 32'h0);
    chk("s6_rst_gid", 32'(grant_id), 32'h0);
    chk("s6_rst_ready2", 32'(req_ready), 32'h0);
    rst_n = 1'b1; #1;
    chk("s6_rel_ready", 32'(req_ready), 32'b0001);
    cyc();
    req_valid[0] = 1'b0; #1;
    chk("s6_disp0", 32'(disp_value), 32'h1111);
    chk("s6_gid0", 32'(grant_id), 32'h0);
    chk("s6_active0", 32'(disp_active), 32'h1);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_display_arbiter.md
Name: led_display_arbiter

Overview:
Shares the single 16-bit LED nibble display between NUM_REQ requesters (status, error codes, debug counters).
- Accepts a 16-bit value from one requester at a time, chosen round-robin.
- Drives that value to the display for a guaranteed minimum hold time, long enough for a full 4-nibble scan to be read by eye.
- Shows IDLE_VALUE when no requester is active.
- Sits between requesters and led_nibble_display; disp_value connects to the display's value input.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 48_000_000, clk cycles each accepted value is held (4 s at 12 MHz); must be >= 2
IDLE_VALUE, 16'h0000, value driven when no grant is active

Ports:
clk  input  1  system clock, 12 MHz
rst_n  input  1  reset, synchronous, active-low
req_valid  input  NUM_REQ  per-requester valid; requester holds it and its value stable until accepted
req_value  input  NUM_REQ*16  packed values; requester i occupies bits [16*i+15:16*i]
req_ready  output  NUM_REQ  one-hot accept strobe, combinational; transfer when req_valid[i] && req_ready[i]
disp_value  output  16  value to led_nibble_display
disp_active  output  1  high while a granted value is being held
grant_id  output  $clog2(NUM_REQ)  index of requester currently shown

Behaviour:
- Reset:
  - Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
  - Registered state after a clk edge with rst_n low: state=IDLE, disp_value=IDLE_VALUE, disp_active=0, grant_id=0, hold counter=0, rr pointer last=NUM_REQ-1 (requester 0 has first priority).
  - req_ready is forced to 0 while rst_n is low.
- State machine, two states:
  - IDLE: disp_active=0.
  - SHOW: disp_active=1; counter increments from 0 each cycle.
- Accept cycle: any cycle where state==IDLE, or state==SHOW with counter==HOLD_CYCLES-1.
  - In an accept cycle with any req_valid high, the arbiter picks the first valid index searching last+1, last+2, ... wrapping modulo NUM_REQ. It asserts req_ready for that index only.
  - Next edge: disp_value <= selected req_value, grant_id <= index, last <= index, counter <= 0, state <= SHOW.
  - Latency: value is visible on disp_value 1 cycle after acceptance.
- SHOW expiry with no req_valid high: next edge state <= IDLE, disp_value <= IDLE_VALUE, disp_active <= 0. grant_id keeps its last value.
- Back-to-back accepts: new value follows the old one with no idle gap. Each value is held exactly HOLD_CYCLES cycles.
- Same requester re-requesting at expiry: granted again only if no other requester is valid (fairness). It may be granted consecutively when it is the sole requester.
- req_ready is 0 in every non-accept cycle. A request arriving mid-hold waits.
- A requester may drop req_valid before acceptance (withdraw); no grant is recorded for it.
- Counter width: $clog2(HOLD_CYCLES). The counter never exceeds HOLD_CYCLES-1.
- Reset asserted mid-SHOW: next edge returns to the full reset state; the held value is discarded; no req_ready that cycle.
- req_value bits of ungranted requesters are ignored.

Decomposition:
- Package led_display_pkg:
  - VALUE_W=16, NIBBLE_W=4, CLK_HZ=12_000_000
  - typedef disp_value_t (logic [VALUE_W-1:0])
  - typedef arb_state_e {IDLE, SHOW}
- Sub-module rr_arbiter (parameter N):
  - Purely combinational.
  - Inputs: req[N], last pointer, enable.
  - Outputs: one-hot grant[N], grant index, any_grant.
  - Instantiated once; the FSM, counter and registers stay in led_display_arbiter.

Test Plan:
All scenarios use NUM_REQ=4, HOLD_CYCLES=8, IDLE_VALUE=16'h0000.
1. Reset, no requests: disp_value=16'h0000, disp_active=0, req_ready=4'b0000 for 20 cycles.
2. req_valid=4'b0010, value1=16'hC931 in IDLE: req_ready=4'b0010 the same cycle. Next cycle disp_value=16'hC931, grant_id=1, disp_active=1 for exactly 8 cycles, then disp_value=16'h0000.
3. All four valid simultaneously, values 16'h1111..16'h4444 held until accepted: grants in order 0,1,2,3. Each value is shown 8 cycles, back-to-back with no idle gap. Total of 32 active cycles, then idle.
4. Fairness: req0 asserts valid continuously and req2 raises valid at cycle 3 of req0's hold. At expiry, req2 is granted and req0 waits. req0 is granted at req2's expiry.
5. Withdraw: req3 raises valid during a hold, then drops it before expiry with no other requester valid. No req_ready[3]; the display returns to IDLE_VALUE after expiry.
6. Reset mid-hold: rst_n low at hold cycle 4 → next edge disp_value=16'h0000, disp_active=0, grant_id=0. With all four valid after release, requester 0 is granted first.
